// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared types, scancode constants and the set-2 to Apple-1 ASCII map
package ps2_kbd_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_F12    = 8'h07;

    // Returns {valid, ascii[6:0]}; letters stay uppercase, ctrl folds them to 0x01..0x1A
    function automatic logic [7:0] scancode_to_ascii(input logic [7:0] code,
                                                     input logic shift,
                                                     input logic ctrl);
        logic [6:0] base;
        logic [6:0] alt;
        logic       hit;
        logic       letter;
        logic [6:0] ascii;
        base = 7'h00;
        alt  = 7'h00;
        hit  = 1'b1;
        case (code)
            8'h1C: base = 7'h41;  8'h32: base = 7'h42;  8'h21: base = 7'h43;
            8'h23: base = 7'h44;  8'h24: base = 7'h45;  8'h2B: base = 7'h46;
            8'h34: base = 7'h47;  8'h33: base = 7'h48;  8'h43: base = 7'h49;
            8'h3B: base = 7'h4A;  8'h42: base = 7'h4B;  8'h4B: base = 7'h4C;
            8'h3A: base = 7'h4D;  8'h31: base = 7'h4E;  8'h44: base = 7'h4F;
            8'h4D: base = 7'h50;  8'h15: base = 7'h51;  8'h2D: base = 7'h52;
            8'h1B: base = 7'h53;  8'h2C: base = 7'h54;  8'h3C: base = 7'h55;
            8'h2A: base = 7'h56;  8'h1D: base = 7'h57;  8'h22: base = 7'h58;
            8'h35: base = 7'h59;  8'h1A: base = 7'h5A;
            8'h16: begin base = 7'h31; alt = 7'h21; end
            8'h1E: begin base = 7'h32; alt = 7'h40; end
            8'h26: begin base = 7'h33; alt = 7'h23; end
            8'h25: begin base = 7'h34; alt = 7'h24; end
            8'h2E: begin base = 7'h35; alt = 7'h25; end
            8'h36: begin base = 7'h36; alt = 7'h5E; end
            8'h3D: begin base = 7'h37; alt = 7'h26; end
            8'h3E: begin base = 7'h38; alt = 7'h2A; end
            8'h46: begin base = 7'h39; alt = 7'h28; end
            8'h45: begin base = 7'h30; alt = 7'h29; end
            8'h4E: begin base = 7'h2D; alt = 7'h5F; end
            8'h55: begin base = 7'h3D; alt = 7'h2B; end
            8'h41: begin base = 7'h2C; alt = 7'h3C; end
            8'h49: begin base = 7'h2E; alt = 7'h3E; end
            8'h4A: begin base = 7'h2F; alt = 7'h3F; end
            8'h4C: begin base = 7'h3B; alt = 7'h3A; end
            8'h52: begin base = 7'h27; alt = 7'h22; end
            8'h29: begin base = 7'h20; alt = 7'h20; end
            8'h5A: begin base = 7'h0D; alt = 7'h0D; end
            8'h76: begin base = 7'h1B; alt = 7'h1B; end
            8'h66: begin base = 7'h5F; alt = 7'h5F; end
            default: hit = 1'b0;
        endcase
        letter = (base >= 7'h41) && (base <= 7'h5A);
        if (letter)
            ascii = ctrl ? (base - 7'h40) : base;
        else
            ascii = shift ? alt : base;
        return {hit, ascii};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - peripheral bus bundle between the CPU and the keyboard registers
interface ps2_kbd_rx_if;
    logic       enable;
    logic       address;
    logic       w_en;
    logic [7:0] dout;

    modport master (output enable, address, w_en, input dout);
    modport slave  (input enable, address, w_en, output dout);
endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line conditioning and 11-bit frame receiver with mid-frame timeout
import ps2_kbd_pkg::*;

module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic       byte_valid,
    output logic [7:0] data_byte
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, din_sync;
    logic          clk_filt, strobe;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    bit_cnt;
    logic          par_bit, frame_ok;
    logic          din;
    frame_state_t  state, state_next;

    assign din = din_sync[1];

    // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk25) begin
        if (rst) begin
            clk_sync <= 2'b11;
            din_sync <= 2'b11;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            din_sync <= {din_sync[0], ps2_din};
            strobe   <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                strobe   <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        if (strobe) begin
            case (state)
                IDLE:    if (!din) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    frame_ok   = din && (^{data_byte, par_bit});
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            byte_valid <= 1'b0;
            data_byte  <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
        end else begin
            byte_valid <= frame_ok;
            if (strobe || state == IDLE) to_cnt <= '0;
            else                         to_cnt <= to_cnt + 1'b1;
            if (state == IDLE) bit_cnt <= '0;
            if (strobe && state == DATA) begin
                data_byte <= {din, data_byte[7:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (strobe && state == PARITY) par_bit <= din;
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - Apple-1 KBD/KBDCR keyboard port; KBD_CLR_SCREEN_EN turns F12 into a clr_screen pulse
import ps2_kbd_pkg::*;

module ps2_kbd_rx #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_din,
    ps2_kbd_rx_if.slave   bus,
    output logic          clr_screen
);
    logic       byte_valid;
    logic [7:0] data_byte;
    logic       ext, brk, shift_held, ctrl_held;
    logic [6:0] kbd_data;
    logic       ready;
    logic [7:0] lookup;
    logic       is_prefix, is_mod, char_valid, read_clr;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FILTER_LEN(FILTER_LEN)) u_frame (
        .clk25(clk25), .rst(rst), .ps2_clk(ps2_clk), .ps2_din(ps2_din),
        .byte_valid(byte_valid), .data_byte(data_byte)
    );

    assign lookup     = scancode_to_ascii(data_byte, shift_held, ctrl_held);
    assign is_prefix  = (data_byte == PFX_EXT) || (data_byte == PFX_BRK);
    assign is_mod     = (data_byte == SC_LSHIFT) || (data_byte == SC_RSHIFT) || (data_byte == SC_CTRL);
    assign char_valid = byte_valid && !is_prefix && !ext && !brk && !is_mod && lookup[7];
    assign read_clr   = bus.enable && !bus.w_en && !bus.address;

    assign bus.dout = bus.address ? {ready, 7'b0} : {1'b1, kbd_data};

    always_ff @(posedge clk25) begin
        if (rst) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            shift_held <= 1'b0;
            ctrl_held  <= 1'b0;
            kbd_data   <= '0;
            ready      <= 1'b0;
        end else begin
            if (byte_valid) begin
                if (data_byte == PFX_EXT) begin
                    ext <= 1'b1;
                end else if (data_byte == PFX_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && (data_byte == SC_LSHIFT || data_byte == SC_RSHIFT))
                        shift_held <= !brk;
                    if (!ext && data_byte == SC_CTRL)
                        ctrl_held <= !brk;
                end
            end
            // A landing character beats a same-cycle read clear
            if (char_valid) begin
                kbd_data <= lookup[6:0];
                ready    <= 1'b1;
            end else if (read_clr) begin
                ready <= 1'b0;
            end
        end
    end

`ifdef KBD_CLR_SCREEN_EN
    always_ff @(posedge clk25) begin
        if (rst) clr_screen <= 1'b0;
        else     clr_screen <= byte_valid && !ext && !brk && (data_byte == SC_F12);
    end
`else
    assign clr_screen = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed table-driven bench for ps2_kbd_rx
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_din = 1'b1;
    logic clr_screen;
    int   total = 0;
    int   bad = 0;
    int   clr_cycles = 0;

`ifdef KBD_CLR_SCREEN_EN
    localparam int EXP_CLR = 1;
`else
    localparam int EXP_CLR = 0;
`endif

    ps2_kbd_rx_if bus ();

    ps2_kbd_rx dut (
        .clk25(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_din(ps2_din),
        .bus(bus), .clr_screen(clr_screen)
    );

    always #20 clk = ~clk;

    always @(posedge clk) if (!rst && clr_screen) clr_cycles <= clr_cycles + 1;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        logic       exp_ready;
        logic [7:0] exp_d0;
        bit         clear_after;
    } vec_t;

    vec_t tbl [15];

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic rd(input logic a, output logic [7:0] v);
        @(negedge clk);
        bus.address = a;
        #1 v = bus.dout;
    endtask

    task automatic read_clear();
        @(negedge clk);
        bus.enable = 1'b1; bus.address = 1'b0; bus.w_en = 1'b0;
        @(negedge clk);
        bus.enable = 1'b0;
    endtask

    // Start, 8 data LSB first, odd parity, stop; nfalls < 11 truncates the frame
    task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nfalls);
        logic [10:0] bits;
        logic        par;
        par  = ~(^code) ^ bad_par;
        bits = {1'b1, par, code, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            ps2_din = bits[i];
            repeat (20) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (40) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (20) @(posedge clk);
        end
        ps2_din = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    logic [7:0] v;
    bit         seen;

    initial begin
        bus.enable = 1'b0; bus.address = 1'b0; bus.w_en = 1'b0;

        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 8'hC1, 1'b1};
        tbl[1]  = '{8'h12, 1'b0, 1'b0, 8'hC1, 1'b0};
        tbl[2]  = '{8'h16, 1'b0, 1'b1, 8'hA1, 1'b1};
        tbl[3]  = '{8'hF0, 1'b0, 1'b0, 8'hA1, 1'b0};
        tbl[4]  = '{8'h16, 1'b0, 1'b0, 8'hA1, 1'b0};
        tbl[5]  = '{8'hF0, 1'b0, 1'b0, 8'hA1, 1'b0};
        tbl[6]  = '{8'h12, 1'b0, 1'b0, 8'hA1, 1'b0};
        tbl[7]  = '{8'h16, 1'b0, 1'b1, 8'hB1, 1'b1};
        tbl[8]  = '{8'h1C, 1'b1, 1'b0, 8'hB1, 1'b0};
        tbl[9]  = '{8'h5A, 1'b0, 1'b1, 8'h8D, 1'b1};
        tbl[10] = '{8'hE0, 1'b0, 1'b0, 8'h8D, 1'b0};
        tbl[11] = '{8'h1C, 1'b0, 1'b0, 8'h8D, 1'b0};
        tbl[12] = '{8'h66, 1'b0, 1'b1, 8'hDF, 1'b1};
        tbl[13] = '{8'h76, 1'b0, 1'b1, 8'h9B, 1'b1};
        tbl[14] = '{8'h29, 1'b0, 1'b1, 8'hA0, 1'b1};

        repeat (4) @(posedge clk);
        rst = 1'b0;
        rd(1'b1, v); check8("reset_kbdcr", v, 8'h00);
        rd(1'b0, v); check8("reset_kbd", v, 8'h80);
        check8("reset_clr", {7'b0, clr_screen}, 8'h00);

        for (int i = 0; i < 15; i++) begin
            send_frame(tbl[i].code, tbl[i].bad_par, 11);
            rd(1'b1, v); check8($sformatf("vec%0d_ready", i), v, {tbl[i].exp_ready, 7'b0});
            rd(1'b0, v); check8($sformatf("vec%0d_data", i), v, tbl[i].exp_d0);
            if (tbl[i].clear_after) begin
                read_clear();
                rd(1'b1, v); check8($sformatf("vec%0d_cleared", i), v, 8'h00);
            end
        end

        // F12 make: pulse only when the option is built in, never a character
        send_frame(8'h07, 1'b0, 11);
        rd(1'b1, v); check8("f12_ready", v, 8'h00);
        rd(1'b0, v); check8("f12_data", v, 8'hA0);
        check8("f12_clr_cycles", 8'(clr_cycles), 8'(EXP_CLR));

        // Truncated frame then timeout; the next frame must decode cleanly
        send_frame(8'h1C, 1'b0, 5);
        repeat (26000) @(posedge clk);
        send_frame(8'h32, 1'b0, 11);
        rd(1'b1, v); check8("timeout_ready", v, 8'h80);
        rd(1'b0, v); check8("timeout_data", v, 8'hC2);

        // Writes to KBD do not clear ready
        @(negedge clk);
        bus.enable = 1'b1; bus.address = 1'b0; bus.w_en = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0; bus.w_en = 1'b0;
        rd(1'b1, v); check8("write_ignored", v, 8'h80);

        // Ctrl+C lands on the same cycle as a read strobe while ready is already set
        send_frame(8'h14, 1'b0, 11);
        rd(1'b1, v); check8("ctrl_make_ready", v, 8'h80);
        seen = 1'b0;
        fork
            send_frame(8'h21, 1'b0, 11);
            begin
                for (int c = 0; c < 2000 && !seen; c++) begin
                    @(negedge clk);
                    if (dut.u_frame.byte_valid) seen = 1'b1;
                end
                if (seen) begin
                    bus.enable = 1'b1; bus.address = 1'b0; bus.w_en = 1'b0;
                    @(negedge clk);
                    bus.enable = 1'b0;
                end
            end
        join
        check8("collide_seen", {7'b0, seen}, 8'h01);
        rd(1'b1, v); check8("collide_ready", v, 8'h80);
        rd(1'b0, v); check8("collide_data", v, 8'h83);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h14, 1'b0, 11);
        read_clear();

        // Reset mid-frame loses the frame; the next start bit resynchronises
        send_frame(8'h24, 1'b0, 6);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk); rst = 1'b0;
        rd(1'b1, v); check8("midreset_kbdcr", v, 8'h00);
        rd(1'b0, v); check8("midreset_kbd", v, 8'h80);
        send_frame(8'h1C, 1'b0, 11);
        rd(1'b1, v); check8("resync_ready", v, 8'h80);
        rd(1'b0, v); check8("resync_data", v, 8'hC1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
